sad_candidate_streamer: RTL and testbench

//  Producer side of the motion-search SAD stream. Scans every candidate position of a
//  BLK x BLK reference block inside a FRM_W x FRM_H search frame in raster order.

---
 rtl/sad_candidate_streamer.sv | 189 ++++++++++++++++++
 tb/tb_sad_candidate_streamer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sad_candidate_streamer.sv
// Raster-scans every BLK x BLK candidate position of a search frame and streams one
// (x, y, SAD) record per candidate, with synchronous-read reference/frame memories.
module sad_candidate_streamer #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned BLK   = 4,
   parameter int unsigned FRM_W = 16,
   parameter int unsigned FRM_H = 16
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(BLK*BLK)-1:0]     ref_addr,
   input  logic [PIX_W-1:0]               ref_data,
   output logic [$clog2(FRM_W*FRM_H)-1:0] frm_addr,
   input  logic [PIX_W-1:0]               frm_data,
   output logic signed [31:0]             x_coor,
   output logic signed [31:0]             y_coor,
   output logic signed [31:0]             newSad,
   output logic                           sad_valid
);

   localparam int unsigned RAW  = $clog2(BLK*BLK);
   localparam int unsigned FAW  = $clog2(FRM_W*FRM_H);
   localparam int unsigned CW   = $clog2(BLK) + 1;
   localparam int unsigned XW   = $clog2(FRM_W) + 1;
   localparam int unsigned YW   = $clog2(FRM_H) + 1;
   localparam int unsigned XMAX = FRM_W - BLK;
   localparam int unsigned YMAX = FRM_H - BLK;

   typedef enum logic [2:0] {IDLE, ACC, DRAIN, EMIT, DONE} state_t;

   state_t state_q, state_nx;

   logic [CW-1:0]    i_q, j_q, i_d, j_d, ni, nj;
   logic [XW-1:0]    x_q, x_d, nx;
   logic [YW-1:0]    y_q, y_d, ny;
   logic [31:0]      acc_q, acc_d;
   logic [RAW-1:0]   ref_addr_d;
   logic [FAW-1:0]   frm_addr_d;
   logic [31:0]      x_coor_d, y_coor_d, newSad_d;
   logic             sad_valid_d, busy_d, done_d;
   logic [PIX_W-1:0] diff;
   logic             last_pair, last_cand;

   function automatic logic [FAW-1:0] frm_at(input logic [XW-1:0] xa, input logic [YW-1:0] ya,
                                             input logic [CW-1:0] ia, input logic [CW-1:0] ja);
      logic [31:0] a;
      a = (32'(ya) + 32'(ia)) * FRM_W + 32'(xa) + 32'(ja);
      return FAW'(a);
   endfunction

   function automatic logic [RAW-1:0] ref_at(input logic [CW-1:0] ia, input logic [CW-1:0] ja);
      logic [31:0] a;
      a = 32'(ia) * BLK + 32'(ja);
      return RAW'(a);
   endfunction

   assign last_pair = (i_q == CW'(BLK-1)) && (j_q == CW'(BLK-1));
   assign last_cand = (x_q == XW'(XMAX)) && (y_q == YW'(YMAX));
   assign diff      = (ref_data > frm_data) ? (ref_data - frm_data) : (frm_data - ref_data);

   // Next pixel pair within the block (j fastest) and next candidate in raster order.
   always_comb begin
      nj = j_q + CW'(1);
      ni = i_q;
      if (j_q == CW'(BLK-1)) begin
         nj = '0;
         ni = i_q + CW'(1);
      end
      nx = x_q + XW'(1);
      ny = y_q;
      if (x_q == XW'(XMAX)) begin
         nx = '0;
         ny = y_q + YW'(1);
      end
   end

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (start) state_nx = ACC;
         ACC:     if (last_pair) state_nx = DRAIN;
         DRAIN:   state_nx = EMIT;
         EMIT:    state_nx = last_cand ? DONE : ACC;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      i_d         = i_q;
      j_d         = j_q;
      x_d         = x_q;
      y_d         = y_q;
      acc_d       = acc_q;
      ref_addr_d  = ref_addr;
      frm_addr_d  = frm_addr;
      x_coor_d    = x_coor;
      y_coor_d    = y_coor;
      newSad_d    = newSad;
      sad_valid_d = 1'b0;
      done_d      = (state_q == DONE);
      busy_d      = (state_nx != IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               i_d        = '0;
               j_d        = '0;
               x_d        = '0;
               y_d        = '0;
               acc_d      = '0;
               ref_addr_d = '0;
               frm_addr_d = '0;
            end
         end
         ACC: begin
            // The pair issued on the first cycle of a candidate returns one cycle later.
            if ((i_q != '0) || (j_q != '0)) acc_d = acc_q + 32'(diff);
            if (!last_pair) begin
               i_d        = ni;
               j_d        = nj;
               ref_addr_d = ref_at(ni, nj);
               frm_addr_d = frm_at(x_q, y_q, ni, nj);
            end
         end
         DRAIN: acc_d = acc_q + 32'(diff);
         EMIT: begin
            newSad_d    = acc_q;
            x_coor_d    = 32'(x_q);
            y_coor_d    = 32'(y_q);
            sad_valid_d = 1'b1;
            acc_d       = '0;
            i_d         = '0;
            j_d         = '0;
            if (!last_cand) begin
               x_d        = nx;
               y_d        = ny;
               ref_addr_d = '0;
               frm_addr_d = frm_at(nx, ny, '0, '0);
            end
         end
         default: ;
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         i_q       <= '0;
         j_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         acc_q     <= '0;
         ref_addr  <= '0;
         frm_addr  <= '0;
         x_coor    <= '0;
         y_coor    <= '0;
         newSad    <= '0;
         sad_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         i_q       <= i_d;
         j_q       <= j_d;
         x_q       <= x_d;
         y_q       <= y_d;
         acc_q     <= acc_d;
         ref_addr  <= ref_addr_d;
         frm_addr  <= frm_addr_d;
         x_coor    <= x_coor_d;
         y_coor    <= y_coor_d;
         newSad    <= newSad_d;
         sad_valid <= sad_valid_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_sad_candidate_streamer.sv
// Directed bench for sad_candidate_streamer on a 4x4 block in an 8x8 frame
// (25 candidates, 18 cycles per record).
module tb_sad_candidate_streamer;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned BLK   = 4;
   localparam int unsigned FRM_W = 8;
   localparam int unsigned FRM_H = 8;
   localparam int NX   = FRM_W - BLK + 1;
   localparam int NY   = FRM_H - BLK + 1;
   localparam int NREC = NX * NY;
   localparam int GAP  = BLK * BLK + 2;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              start;
   logic              busy, done, sad_valid;
   logic [3:0]        ref_addr;
   logic [5:0]        frm_addr;
   logic [PIX_W-1:0]  ref_data, frm_data;
   logic signed [31:0] x_coor, y_coor, newSad;

   logic [PIX_W-1:0] ref_mem [16];
   logic [PIX_W-1:0] frm_mem [64];

   int n_tests = 0;
   int n_fail  = 0;

   sad_candidate_streamer #(.PIX_W(PIX_W), .BLK(BLK), .FRM_W(FRM_W), .FRM_H(FRM_H)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .busy(busy), .done(done),
      .ref_addr(ref_addr), .ref_data(ref_data), .frm_addr(frm_addr), .frm_data(frm_data),
      .x_coor(x_coor), .y_coor(y_coor), .newSad(newSad), .sad_valid(sad_valid)
   );

   always #5 Clk = ~Clk;

   // Synchronous-read memories, one cycle of latency
   always @(posedge Clk) begin
      ref_data <= ref_mem[ref_addr];
      frm_data <= frm_mem[frm_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input int rv, input int fv);
      for (int k = 0; k < 16; k++) ref_mem[k] = PIX_W'(rv);
      for (int k = 0; k < 64; k++) frm_mem[k] = PIX_W'(fv);
   endtask

   // mode 0: every record has SAD exp_sad; mode 3: block copy at (3,2)
   task automatic scan(input int mode, input int exp_sad, input bit inject);
      int rec, cyc, best, bx, by, ex, ey;
      bit fin;
      rec = 0; cyc = 0; best = 9999; bx = -1; by = -1; fin = 0;
      @(negedge Clk) start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      check("busy_rise", 32'(busy), 1);
      while (!fin && cyc < NREC * GAP + 20) begin
         @(posedge Clk);
         #1;
         cyc++;
         start = (inject && cyc == GAP * 5 + 7) ? 1'b1 : 1'b0;
         if (sad_valid) begin
            ex = rec % NX;
            ey = rec / NX;
            check("rec_time", cyc, GAP * (rec + 1));
            check("rec_x", x_coor, ex);
            check("rec_y", y_coor, ey);
            if (mode == 3) begin
               if (rec == 0)             check("t3_sad_00", newSad, 3498);
               else if (rec == NREC - 1) check("t3_sad_44", newSad, 2502);
               else check("t3_zero_only_32", 32'(newSad == 0), 32'(ex == 3 && ey == 2));
            end else begin
               check("rec_sad", newSad, exp_sad);
            end
            if (newSad < best) begin
               best = newSad; bx = x_coor; by = y_coor;
            end
            rec++;
         end
         if (done) begin
            check("done_time", cyc, GAP * NREC + 1);
            check("done_busy_low", 32'(busy), 0);
            check("rec_count", rec, NREC);
            fin = 1;
         end
      end
      if (!fin) check("done_timeout", 0, 1);
      if (mode == 3) begin
         check("t3_best_x", bx, 3);
         check("t3_best_y", by, 2);
      end
      repeat (3) begin
         @(posedge Clk);
         #1;
         check("post_quiet", 32'({sad_valid, done, busy}), 0);
      end
      check("hold_x", x_coor, NX - 1);
      check("hold_y", y_coor, NY - 1);
   endtask

   initial begin
      Rst   = 1'b1;
      start = 1'b0;
      fill(0, 0);
      repeat (2) @(posedge Clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_valid", 32'(sad_valid), 0);
      check("rst_x", x_coor, 0);
      check("rst_y", y_coor, 0);
      check("rst_sad", newSad, 0);
      @(negedge Clk) Rst = 1'b0;
      repeat (2) @(posedge Clk);

      // All zeros
      scan(0, 0, 1'b0);
      // Ref 10, frame 7: 16 * 3
      fill(10, 7);
      scan(0, 48, 1'b0);
      // Ref 0..15, copied into the frame at (3,2), 255 elsewhere
      fill(0, 255);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            ref_mem[i*4 + j]             = PIX_W'(i*4 + j);
            frm_mem[(2 + i)*8 + (3 + j)] = PIX_W'(i*4 + j);
         end
      scan(3, 0, 1'b0);
      // Full-scale difference in both operand orders
      fill(0, 255);
      scan(0, 4080, 1'b0);
      fill(255, 0);
      scan(0, 4080, 1'b0);
      // Start pulsed again mid-scan must be ignored
      fill(10, 7);
      scan(0, 48, 1'b1);

      // Asynchronous reset in the middle of candidate 7
      fill(0, 0);
      @(negedge Clk) start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      repeat (GAP * 6 + 5) @(posedge Clk);
      #1;
      check("pre_rst_busy", 32'(busy), 1);
      check("pre_rst_y", y_coor, 1);
      Rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_valid", 32'(sad_valid), 0);
      check("mid_rst_x", x_coor, 0);
      check("mid_rst_y", y_coor, 0);
      check("mid_rst_sad", newSad, 0);
      @(negedge Clk) Rst = 1'b0;
      repeat (GAP + 2) @(posedge Clk);
      #1;
      check("after_rst_idle", 32'({sad_valid, busy, done}), 0);
      scan(0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
